pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 255, consecutive MEM_WAIT cycles (1..255) before mem_timeout_o sets.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: id_rs1_i, id_rs2_i  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port: id_uses_rs2_i  input  1  ID instruction reads rs2 (R-type, sd, beq).
REQ-006 SHALL have ports: ex_memread_i  input  1 (ld in EX); ex_rd_i  input  5 (EX destination).
REQ-007 SHALL have ports: ex_branch_i, ex_zero_i  input  1 each  beq in EX; ALU zero flag.
REQ-008 SHALL have ports: mem_req_i  input  1 (ld/sd in MEM); mem_ready_i  input  1 (data memory done).
REQ-009 SHALL have outputs, 1 bit each: pc_write_o, pc_sel_o (1 = branch target), ifid_write_o, ifid_flush_o, idex_flush_o, exmem_write_o, memwb_bubble_o, mem_timeout_o.
REQ-010 SHALL have outputs: state_o  2 (00 RUN, 01 LU_STALL, 10 MEM_WAIT); stall_cnt_o, flush_cnt_o  16 each.

Function
REQ-011 Outputs SHALL be combinational from current state and inputs; state, timer, counters, mem_timeout_o are registered.
REQ-012 Defaults (no event): pc_write_o=1, ifid_write_o=1, exmem_write_o=1, all others 0.
REQ-013 Priority SHALL be: memory freeze > branch flush > load-use stall.
REQ-014 Freeze when mem_req_i=1 and mem_ready_i=0: pc_write_o=ifid_write_o=exmem_write_o=0, memwb_bubble_o=1, flush outputs 0; next state MEM_WAIT.
REQ-015 MEM_WAIT SHALL hold freeze while mem_ready_i=0; in the cycle mem_ready_i=1 freeze releases (defaults apply, branch/load-use evaluated normally), next state RUN or LU_STALL per REQ-017.
REQ-016 Branch taken (ex_branch_i & ex_zero_i, no freeze): pc_sel_o=1, pc_write_o=1, ifid_flush_o=1, idex_flush_o=1; load-use ignored that cycle.
REQ-017 Load-use (no freeze, no taken branch): ex_memread_i=1, ex_rd_i!=0, ex_rd_i==id_rs1_i or (id_uses_rs2_i and ex_rd_i==id_rs2_i) -> pc_write_o=0, ifid_write_o=0, idex_flush_o=1; next state LU_STALL.
REQ-018 LU_STALL SHALL last exactly one cycle, evaluating inputs as RUN, then RUN unless a freeze or new load-use applies.
REQ-019 Register x0 SHALL never cause a load-use stall.
REQ-020 MEM_WAIT timer SHALL count consecutive freeze cycles, clear on leaving MEM_WAIT; reaching TIMEOUT_CYC sets sticky mem_timeout_o; freeze behaviour unchanged.
REQ-021 mem_timeout_o SHALL clear only on reset.

Reset
REQ-022 rst_i low SHALL immediately force state RUN, timer 0, mem_timeout_o 0, counters 0, pc_write_o=ifid_write_o=exmem_write_o=0, all other outputs 0.
REQ-023 Reset asserted mid-MEM_WAIT or mid-LU_STALL SHALL abandon the sequence; first cycle after release is RUN.

Configuration
REQ-024 Macro HAZARD_PERF_CNT_EN defined: stall_cnt_o increments each non-reset cycle with pc_write_o=0; flush_cnt_o increments each taken-branch flush; both saturate at 16'hFFFF.
REQ-025 Macro HAZARD_PERF_CNT_EN undefined: stall_cnt_o and flush_cnt_o tied to 0, no counter registers; ports remain.

Verification
REQ-026 ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 -> one cycle pc_write_o=0, idex_flush_o=1, state_o=01, then 00; stall_cnt_o=1.
REQ-027 ex_memread_i=1, ex_rd_i=0, id_rs1_i=0 -> no stall, pc_write_o=1, state_o=00.
REQ-028 ex_branch_i=1, ex_zero_i=1 with load-use also true -> pc_sel_o=1, ifid_flush_o=1, idex_flush_o=1, pc_write_o=1; flush_cnt_o=1.
REQ-029 mem_req_i=1, mem_ready_i=0 for 3 cycles then 1, branch taken throughout -> 3 freeze cycles (state_o=10, memwb_bubble_o=1, pc_sel_o=0), 4th cycle pc_sel_o=1.
REQ-030 TIMEOUT_CYC=4, mem_ready_i held 0 for 6 cycles -> mem_timeout_o=1 from cycle 4, stays 1 after ready; rst_i low clears it and forces pc_write_o=0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a 5-stage in-order pipeline. Resolves three hazard
//   classes each cycle with fixed priority:
//     data-memory freeze > taken-branch flush > load-use stall.
//   Control outputs are combinational from the current state and inputs.
//   The state, the MEM_WAIT timer, the sticky timeout flag and the optional
//   performance counters are registered.
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue, no hazard carried over
//   LU_ST | one-cycle load-use bubble in flight; inputs evaluated as in RUN
//   MEM_W | data memory busy; pipeline frozen until mem_ready_i
//
// Ports
//   clk_i, rst_i (async, active-low)
//   id_rs1_i, id_rs2_i, id_uses_rs2_i      : ID-stage source operands
//   ex_memread_i, ex_rd_i                  : load in EX and its destination
//   ex_branch_i, ex_zero_i                 : beq in EX and ALU zero flag
//   mem_req_i, mem_ready_i                 : MEM-stage access handshake
//   pc_write_o, pc_sel_o, ifid_write_o, ifid_flush_o, idex_flush_o,
//   exmem_write_o, memwb_bubble_o          : pipeline controls
//   mem_timeout_o                          : sticky, cleared only by reset
//   state_o                                : 00 RUN, 01 LU_STALL, 10 MEM_WAIT
//   stall_cnt_o, flush_cnt_o               : performance counters
//
// Configuration
//   HAZARD_PERF_CNT_EN : when defined, stall_cnt_o counts cycles with
//   pc_write_o=0 and flush_cnt_o counts taken-branch flushes, both
//   saturating. When undefined both ports read 0 and no counters exist.

module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs2_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_branch_i,
  input  logic        ex_zero_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_sel_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exmem_write_o,
  output logic        memwb_bubble_o,
  output logic        mem_timeout_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_LU_STALL = 2'b01;
  localparam logic [1:0] ST_MEM_WAIT = 2'b10;

  localparam logic [7:0] LP_TIMEOUT  = TIMEOUT_CYC[7:0];

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [7:0] r_timer;
  logic [7:0] w_timer_inc;
  logic       r_timeout;

  logic       w_freeze;
  logic       w_branch;
  logic       w_rs_match;
  logic       w_load_use;

  // Once in MEM_WAIT the freeze is held purely by mem_ready_i, so a
  // requester that drops mem_req_i early cannot unfreeze the pipe.
  assign w_freeze   = ~mem_ready_i & (mem_req_i | (r_state == ST_MEM_WAIT));
  assign w_branch   = ex_branch_i & ex_zero_i & ~w_freeze;
  assign w_rs_match = (ex_rd_i == id_rs1_i) |
                      (id_uses_rs2_i & (ex_rd_i == id_rs2_i));
  // x0 is hard-wired zero, so a load to it can never produce a hazard.
  assign w_load_use = ~w_freeze & ~w_branch & ex_memread_i &
                      (ex_rd_i != 5'd0) & w_rs_match;

  // Every control output is gated by rst_i so reset takes effect at once,
  // without waiting for a clock edge.
  always_comb begin
    pc_write_o     = rst_i & ~w_freeze & ~w_load_use;
    pc_sel_o       = rst_i & w_branch;
    ifid_write_o   = rst_i & ~w_freeze & ~w_load_use;
    ifid_flush_o   = rst_i & w_branch;
    idex_flush_o   = rst_i & (w_branch | w_load_use);
    exmem_write_o  = rst_i & ~w_freeze;
    memwb_bubble_o = rst_i & w_freeze;
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_freeze) begin
      w_state_nxt = ST_MEM_WAIT;
    end else if (w_load_use) begin
      w_state_nxt = ST_LU_STALL;
    end
  end

  assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : (r_timer + 8'd1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_RUN;
      r_timer   <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_freeze) begin
        r_timer <= w_timer_inc;
        if (w_timer_inc == LP_TIMEOUT) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_timer <= 8'd0;
      end
    end
  end

  assign state_o       = r_state;
  assign mem_timeout_o = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if ((w_freeze | w_load_use) && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_branch && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = 16'd0;
  assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic        id_uses_rs2_i = 0, ex_memread_i = 0, ex_branch_i = 0, ex_zero_i = 0;
  logic        mem_req_i = 0, mem_ready_i = 1;
  logic        pc_write_o, pc_sel_o, ifid_write_o, ifid_flush_o, idex_flush_o;
  logic        exmem_write_o, memwb_bubble_o, mem_timeout_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  pipe_hazard_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .ex_branch_i(ex_branch_i), .ex_zero_i(ex_zero_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_sel_o(pc_sel_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .exmem_write_o(exmem_write_o), .memwb_bubble_o(memwb_bubble_o),
    .mem_timeout_o(mem_timeout_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        pc_write, pc_sel, ifid_write, ifid_flush, idex_flush;
    logic        exmem_write, bubble, timeout;
    logic [1:0]  state;
    logic [15:0] stall, flush;
  } exp_t;

  exp_t q_exp[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [1:0]  m_state;
  int          m_timer;
  logic        m_to;
  int          m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 2'b00; m_timer = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock: drive inputs, push the model's expectation, compare the DUT
  // combinational outputs against it mid-cycle, then advance both on the edge.
  task automatic step(input logic rq, input logic rdy, input logic br, input logic zr,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u2, input string tag);
    logic frz, tk, lu;
    exp_t e, g;
    mem_req_i = rq; mem_ready_i = rdy; ex_branch_i = br; ex_zero_i = zr;
    ex_memread_i = mr; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs2_i = u2;
    #1;
    frz = !rdy && (rq || m_state == 2'b10);
    tk  = br && zr && !frz;
    lu  = !frz && !tk && mr && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
    e.pc_write    = !frz && !lu;
    e.pc_sel      = tk;
    e.ifid_write  = !frz && !lu;
    e.ifid_flush  = tk;
    e.idex_flush  = tk || lu;
    e.exmem_write = !frz;
    e.bubble      = frz;
    e.timeout     = m_to;
    e.state       = m_state;
`ifdef HAZARD_PERF_CNT_EN
    e.stall = m_stall[15:0];
    e.flush = m_flush[15:0];
`else
    e.stall = 16'd0;
    e.flush = 16'd0;
`endif
    q_exp.push_back(e);
    #1;
    g = q_exp.pop_front();
    chk({tag, ".pc_write"},    pc_write_o,     g.pc_write);
    chk({tag, ".pc_sel"},      pc_sel_o,       g.pc_sel);
    chk({tag, ".ifid_write"},  ifid_write_o,   g.ifid_write);
    chk({tag, ".ifid_flush"},  ifid_flush_o,   g.ifid_flush);
    chk({tag, ".idex_flush"},  idex_flush_o,   g.idex_flush);
    chk({tag, ".exmem_write"}, exmem_write_o,  g.exmem_write);
    chk({tag, ".bubble"},      memwb_bubble_o, g.bubble);
    chk({tag, ".timeout"},     mem_timeout_o,  g.timeout);
    chk({tag, ".state"},       state_o,        g.state);
    chk({tag, ".stall_cnt"},   stall_cnt_o,    g.stall);
    chk({tag, ".flush_cnt"},   flush_cnt_o,    g.flush);
    @(posedge clk_i);
    m_state = frz ? 2'b10 : (lu ? 2'b01 : 2'b00);
    if (frz) begin
      if (m_timer < 255) m_timer++;
      if (m_timer >= TO) m_to = 1;
    end else begin
      m_timer = 0;
    end
    if ((frz || lu) && m_stall < 16'hFFFF) m_stall++;
    if (tk && m_flush < 16'hFFFF) m_flush++;
    #1;
  endtask

  task automatic idle(input string tag);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, tag);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must react without a clock.
  task automatic async_reset(input string tag);
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_pc_write"},    pc_write_o,    1'b0);
    chk({tag, ".rst_ifid_write"},  ifid_write_o,  1'b0);
    chk({tag, ".rst_exmem_write"}, exmem_write_o, 1'b0);
    chk({tag, ".rst_bubble"},      memwb_bubble_o, 1'b0);
    chk({tag, ".rst_state"},       state_o,       2'b00);
    chk({tag, ".rst_timeout"},     mem_timeout_o, 1'b0);
    chk({tag, ".rst_stall"},       stall_cnt_o,   16'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    mem_req_i = 1; mem_ready_i = 0;   // a freeze pattern must be masked by reset
    #3;
    chk("reset.pc_write",    pc_write_o,    1'b0);
    chk("reset.exmem_write", exmem_write_o, 1'b0);
    chk("reset.bubble",      memwb_bubble_o, 1'b0);
    chk("reset.state",       state_o,       2'b00);
    chk("reset.timeout",     mem_timeout_o, 1'b0);
    chk("reset.flush_cnt",   flush_cnt_o,   16'd0);
    @(posedge clk_i); @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;

    idle("idle0");
    // load-use on rs1 then return to RUN
    step(0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, "lu_rs1");
    idle("lu_rs1_after");
    chk("lu_rs1_state_run", state_o, 2'b00);
    // x0 destination never stalls
    step(0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, "lu_x0");
    // rs2 match only counts when rs2 is used
    step(0, 1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, "lu_rs2_used");
    step(0, 1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, "lu_rs2_unused");
    // back-to-back load-use from LU_STALL
    step(0, 1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, "lu_b2b_a");
    step(0, 1, 0, 0, 1, 5'd9, 5'd2, 5'd9, 1, "lu_b2b_b");
    // no load (memread=0) with matching regs
    step(0, 1, 0, 0, 0, 5'd4, 5'd4, 5'd4, 1, "no_load");
    // taken branch overrides load-use; untaken branch lets it through
    step(0, 1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, "br_over_lu");
    step(0, 1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, "br_untaken");
    idle("idle1");
    // freeze 3 cycles with branch pending, then release with branch taken
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, "frz_br");
    chk("frz_br_state_wait", state_o, 2'b10);
    step(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, "frz_release_br");
    idle("idle2");
    // release into a load-use
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "frz_short");
    step(0, 1, 0, 0, 1, 5'd6, 5'd6, 5'd0, 0, "frz_release_lu");
    idle("idle3");
    // timeout: six not-ready cycles with the requester dropping mem_req early
    for (int i = 0; i < 6; i++) step((i < 2), 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "to_wait");
    chk("to_set", mem_timeout_o, 1'b1);
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "to_release");
    idle("to_sticky");
    chk("to_sticky_direct", mem_timeout_o, 1'b1);
    // timer restarts: 3 freeze cycles, release, 3 more must not falsely count as 6
    async_reset("rst_after_to");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "tmr_a");
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "tmr_gap");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "tmr_b");
    chk("tmr_no_timeout", mem_timeout_o, 1'b0);
    // reset while frozen in MEM_WAIT
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, "pre_rst_wait");
    async_reset("rst_mid_wait");
    idle("post_rst_wait");
    // reset while in LU_STALL
    step(0, 1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, "pre_rst_lu");
    async_reset("rst_mid_lu");
    idle("post_rst_lu");
    // random mix
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1), "rand");
    end
    chk("queue_empty", q_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
